// File: rtl/div_result_align.sv
// div_result_align: realigns divider quotients with the sideband tag and
// divide-by-zero flag captured when the operands entered the divider.
// A small register FIFO carries {tag, dz} across the divider latency.
// Each popped result is clamped to OUT_W and re-emitted with its tag.

`timescale 1ns/1ps

module div_result_align #(
  parameter int unsigned WIDTH_N = 16,
  parameter int unsigned WIDTH_D = 16,
  parameter int unsigned SIDE_W  = 16,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter bit          SIGNED  = 1'b1
) (
  input  logic                     i_Sys_clk,
  input  logic                     i_Rst,
  input  logic                     i_din_en,
  input  logic [WIDTH_D-1:0]       i_denom,
  input  logic [SIDE_W-1:0]        i_side,
  input  logic                     i_quotient_en,
  input  logic [WIDTH_N-1:0]       i_quotient,
  input  logic                     i_clr_err,
  output logic                     o_dout_en,
  output logic [OUT_W-1:0]         o_dout,
  output logic [SIDE_W-1:0]        o_side,
  output logic                     o_dz,
  output logic                     o_sat,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = SIDE_W + 1;

  // Clamp bounds; POS_MAX is also the divide-by-zero result.
  localparam logic [OUT_W-1:0] ALL_ONES = '1;
  localparam logic [OUT_W-1:0] POS_MAX  = SIGNED ? (ALL_ONES >> 1) : ALL_ONES;
  localparam logic [OUT_W-1:0] NEG_MIN  = ~(ALL_ONES >> 1);

  // Tag storage: entry = {side, dz}
  logic [EW-1:0]     mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              dout_en_q, dout_en_d;
  logic [OUT_W-1:0]  dout_q, dout_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic              dz_q, dz_d;
  logic              sat_q, sat_d;

  logic              push_ok_c;
  logic              pop_ok_c;
  logic              ovf_set_c;
  logic              udf_set_c;
  logic [EW-1:0]     rd_entry_c;
  logic [OUT_W-1:0]  clamp_val_c;
  logic              clamp_sat_c;
  logic signed [WIDTH_N-1:0] q_hi_s_c;
  logic [WIDTH_N-1:0]        q_hi_u_c;

  // Saturate the raw quotient into the OUT_W output range.
  always_comb begin
    q_hi_s_c    = $signed(i_quotient) >>> (OUT_W - 1);
    q_hi_u_c    = i_quotient >> OUT_W;
    clamp_val_c = i_quotient[OUT_W-1:0];
    clamp_sat_c = 1'b0;
    if (SIGNED) begin
      // In range only when every bit above the output sign bit matches it.
      if (!((q_hi_s_c == '0) || (q_hi_s_c == '1))) begin
        clamp_sat_c = 1'b1;
        clamp_val_c = i_quotient[WIDTH_N-1] ? NEG_MIN : POS_MAX;
      end
    end else begin
      if (q_hi_u_c != '0) begin
        clamp_sat_c = 1'b1;
        clamp_val_c = ALL_ONES;
      end
    end
  end

  // Next-state: FIFO bookkeeping, error flags and the output stage.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    dout_en_d = 1'b0;
    dout_d    = dout_q;
    side_d    = side_q;
    dz_d      = dz_q;
    sat_d     = sat_q;

    rd_entry_c = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // legal when paired with a pop. No bypass at empty: the divider has
    // at least one cycle of latency.
    pop_ok_c  = i_quotient_en && (cnt_q != '0);
    push_ok_c = i_din_en && (!full_q || pop_ok_c);
    ovf_set_c = i_din_en && !push_ok_c;
    udf_set_c = i_quotient_en && !pop_ok_c;

    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok_c, pop_ok_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == CW'(DEPTH));

    // A new error wins over a coincident clear.
    ovf_d = ovf_set_c || (ovf_q && !i_clr_err);
    udf_d = udf_set_c || (udf_q && !i_clr_err);

    if (pop_ok_c) begin
      dout_en_d = 1'b1;
      side_d    = rd_entry_c[EW-1:1];
      dz_d      = rd_entry_c[0];
      if (rd_entry_c[0]) begin
        dout_d = POS_MAX;
        sat_d  = 1'b0;
      end else begin
        dout_d = clamp_val_c;
        sat_d  = clamp_sat_c;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      dout_en_q <= 1'b0;
      dout_q    <= '0;
      side_q    <= '0;
      dz_q      <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      dout_en_q <= dout_en_d;
      dout_q    <= dout_d;
      side_q    <= side_d;
      dz_q      <= dz_d;
      sat_q     <= sat_d;
    end
  end

  // Tag storage write; contents need no reset since count gates reads.
  always_ff @(posedge i_Sys_clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= {i_side, (i_denom == '0)};
  end

  assign o_dout_en = dout_en_q;
  assign o_dout    = dout_q;
  assign o_side    = side_q;
  assign o_dz      = dz_q;
  assign o_sat     = sat_q;
  assign o_full    = full_q;
  assign o_cnt     = cnt_q;
  assign o_ovf     = ovf_q;
  assign o_udf     = udf_q;

endmodule

// File: tb/tb_div_result_align.sv
// Directed bench for div_result_align: a signed and an unsigned instance
// share one stimulus stream; expected values are hand-computed.

`timescale 1ns/1ps

module tb_div_result_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_en, quotient_en, clr_err;
  logic [15:0] denom, side, quotient;

  logic        s_dout_en, s_dz, s_sat, s_full, s_ovf, s_udf;
  logic [7:0]  s_dout;
  logic [15:0] s_side;
  logic [4:0]  s_cnt;
  logic        u_dout_en, u_dz, u_sat, u_full, u_ovf, u_udf;
  logic [7:0]  u_dout;
  logic [15:0] u_side;
  logic [4:0]  u_cnt;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  div_result_align #(.SIGNED(1'b1)) dut_s (
    .i_Sys_clk(clk), .i_Rst(rst), .i_din_en(din_en), .i_denom(denom),
    .i_side(side), .i_quotient_en(quotient_en), .i_quotient(quotient),
    .i_clr_err(clr_err), .o_dout_en(s_dout_en), .o_dout(s_dout),
    .o_side(s_side), .o_dz(s_dz), .o_sat(s_sat), .o_full(s_full),
    .o_cnt(s_cnt), .o_ovf(s_ovf), .o_udf(s_udf)
  );

  div_result_align #(.SIGNED(1'b0)) dut_u (
    .i_Sys_clk(clk), .i_Rst(rst), .i_din_en(din_en), .i_denom(denom),
    .i_side(side), .i_quotient_en(quotient_en), .i_quotient(quotient),
    .i_clr_err(clr_err), .o_dout_en(u_dout_en), .o_dout(u_dout),
    .o_side(u_side), .o_dz(u_dz), .o_sat(u_sat), .o_full(u_full),
    .o_cnt(u_cnt), .o_ovf(u_ovf), .o_udf(u_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] tag, input logic [15:0] d);
    din_en = 1'b1; side = tag; denom = d;
    tick();
    din_en = 1'b0;
  endtask

  task automatic pop(input logic [15:0] q);
    quotient_en = 1'b1; quotient = q;
    tick();
    quotient_en = 1'b0;
  endtask

  task automatic clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din_en = 1'b0; quotient_en = 1'b0; clr_err = 1'b0;
    denom = '0; side = '0; quotient = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_dout_en", 32'(s_dout_en), 32'h0);
    chk("rst_dout",    32'(s_dout),    32'h0);
    chk("rst_cnt",     32'(s_cnt),     32'h0);
    chk("rst_full",    32'(s_full),    32'h0);
    chk("rst_flags",   32'({s_ovf, s_udf, s_dz, s_sat}), 32'h0);
    rst = 1'b0;
    tick();

    // Basic alignment: tags 1..4, quotients arrive 4 cycles after each push
    for (int i = 1; i <= 4; i++) push(16'(i), 16'd5);
    chk("basic_cnt4", 32'(s_cnt), 32'd4);
    pop(16'd3);
    chk("basic_en0",   32'(s_dout_en), 32'h1);
    chk("basic_dout0", 32'(s_dout),    32'd3);
    chk("basic_side0", 32'(s_side),    32'h0001);
    pop(16'd7);
    chk("basic_dout1", 32'(s_dout),    32'd7);
    chk("basic_side1", 32'(s_side),    32'h0002);
    pop(16'd9);
    chk("basic_dout2", 32'(s_dout),    32'd9);
    chk("basic_side2", 32'(s_side),    32'h0003);
    pop(16'd1);
    chk("basic_en3",   32'(s_dout_en), 32'h1);
    chk("basic_dout3", 32'(s_dout),    32'd1);
    chk("basic_side3", 32'(s_side),    32'h0004);
    chk("basic_dzsat", 32'({s_dz, s_sat}), 32'h0);
    tick();
    chk("basic_en_off", 32'(s_dout_en), 32'h0);
    chk("basic_hold",   32'(s_dout),    32'd1);
    chk("basic_cnt0",   32'(s_cnt),     32'd0);

    // Clamping: signed and unsigned instances see the same quotients
    for (int i = 0; i < 4; i++) push(16'(16'h0010 + i), 16'd5);
    pop(16'h0200);
    chk("clamp0_s", 32'({s_sat, s_dout}), 32'h17F);
    chk("clamp0_u", 32'({u_sat, u_dout}), 32'h1FF);
    pop(16'hFF00);
    chk("clamp1_s", 32'({s_sat, s_dout}), 32'h180);
    chk("clamp1_u", 32'({u_sat, u_dout}), 32'h1FF);
    pop(16'hFFF6);
    chk("clamp2_s", 32'({s_sat, s_dout}), 32'h0F6);
    chk("clamp2_u", 32'({u_sat, u_dout}), 32'h1FF);
    pop(16'h007F);
    chk("clamp3_s", 32'({s_sat, s_dout}), 32'h07F);
    chk("clamp3_u", 32'({u_sat, u_dout}), 32'h07F);
    chk("clamp3_side", 32'(s_side), 32'h0013);

    // Divide by zero: quotient ignored, positive max emitted
    push(16'hABCD, 16'd0);
    pop(16'h1234);
    chk("dz_s_dout", 32'(s_dout), 32'h7F);
    chk("dz_s_flag", 32'({s_dz, s_sat}), 32'h2);
    chk("dz_s_side", 32'(s_side), 32'hABCD);
    chk("dz_u_dout", 32'(u_dout), 32'hFF);
    chk("dz_u_flag", 32'({u_dz, u_sat}), 32'h2);

    // Fill, overflow, clear interplay, push+pop while full, drain
    for (int i = 0; i < 16; i++) push(16'(16'h0100 + i), 16'd5);
    chk("full_flag", 32'(s_full), 32'h1);
    chk("full_cnt",  32'(s_cnt),  32'd16);
    chk("full_ovf0", 32'(s_ovf),  32'h0);
    push(16'h01FF, 16'd5);
    chk("ovf_set",  32'(s_ovf), 32'h1);
    chk("ovf_cnt",  32'(s_cnt), 32'd16);
    din_en = 1'b1; side = 16'h01FE; clr_err = 1'b1;
    tick();
    din_en = 1'b0; clr_err = 1'b0;
    chk("ovf_clr_coincide", 32'(s_ovf), 32'h1);
    clr();
    chk("ovf_cleared", 32'(s_ovf), 32'h0);
    din_en = 1'b1; side = 16'h0110; denom = 16'd5;
    quotient_en = 1'b1; quotient = 16'd5;
    tick();
    din_en = 1'b0; quotient_en = 1'b0;
    chk("pp_full_cnt",  32'(s_cnt),     32'd16);
    chk("pp_full_ovf",  32'(s_ovf),     32'h0);
    chk("pp_full_en",   32'(s_dout_en), 32'h1);
    chk("pp_full_side", 32'(s_side),    32'h0100);
    for (int i = 0; i < 16; i++) begin
      pop(16'(i));
      chk("drain_side", 32'(s_side), (i < 15) ? 32'(16'h0101 + i) : 32'h0110);
    end
    chk("drain_dout",  32'(s_dout), 32'd15);
    chk("drain_cnt",   32'(s_cnt),  32'd0);
    chk("drain_full",  32'(s_full), 32'h0);

    // Underflow
    pop(16'h0055);
    chk("udf_no_pulse", 32'(s_dout_en), 32'h0);
    chk("udf_set",      32'(s_udf),     32'h1);
    chk("udf_hold_dout", 32'(s_dout),   32'd15);
    clr();
    chk("udf_cleared", 32'(s_udf), 32'h0);
    din_en = 1'b1; side = 16'h0777; denom = 16'd5;
    quotient_en = 1'b1; quotient = 16'd9;
    tick();
    din_en = 1'b0; quotient_en = 1'b0;
    chk("pp_empty_udf", 32'(s_udf),     32'h1);
    chk("pp_empty_cnt", 32'(s_cnt),     32'd1);
    chk("pp_empty_en",  32'(s_dout_en), 32'h0);
    clr();
    pop(16'd2);
    chk("pp_empty_pop_side", 32'(s_side), 32'h0777);
    chk("pp_empty_pop_dout", 32'(s_dout), 32'd2);
    chk("pp_empty_pop_cnt",  32'(s_cnt),  32'd0);

    // Mid-operation reset discards in-flight tags
    for (int i = 0; i < 5; i++) push(16'(16'h0900 + i), 16'd5);
    chk("prerst_cnt", 32'(s_cnt), 32'd5);
    rst = 1'b1;
    #1;
    chk("midrst_cnt",  32'(s_cnt),  32'd0);
    chk("midrst_dout", 32'(s_dout), 32'h0);
    chk("midrst_side", 32'(s_side), 32'h0);
    chk("midrst_misc", 32'({s_dout_en, s_full, s_ovf, s_udf, s_dz, s_sat}), 32'h0);
    tick();
    rst = 1'b0;
    pop(16'd3);
    chk("postrst_udf", 32'(s_udf),     32'h1);
    chk("postrst_en",  32'(s_dout_en), 32'h0);
    push(16'hAAAA, 16'd5);
    pop(16'h0021);
    chk("postrst_side", 32'(s_side), 32'hAAAA);
    chk("postrst_dout", 32'(s_dout), 32'h21);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time bound so the bench cannot hang
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/div_result_align.md
Name: div_result_align

Overview:
- Sits directly downstream of divider_wrapper.
- Each operand pair entering the divider (din_en) pushes a sideband tag and a divide-by-zero flag into an internal FIFO.
- Each quotient leaving the divider (quotient_en) pops one tag. The quotient is clamped to the output pixel width and re-emitted together with its original sideband.
- This keeps pixel coordinates and flags aligned with results whatever the divider's pipeline latency.

Parameters:
- WIDTH_N, 16, numerator and quotient width (matches divider LPM_WIDTHN)
- WIDTH_D, 16, denominator width (matches divider LPM_WIDTHD)
- SIDE_W, 16, sideband tag width
- OUT_W, 8, output result width, OUT_W <= WIDTH_N
- DEPTH, 16, tag FIFO depth, power of 2, must be >= divider latency + 1
- SIGNED, 1, 1 = quotient is two's complement (divider "SIGNED"), 0 = unsigned

Ports:
- i_Sys_clk  in  1  system clock
- i_Rst  in  1  asynchronous active-high reset
- i_din_en  in  1  same strobe that drives divider din_en
- i_denom  in  WIDTH_D  same denominator presented to divider
- i_side  in  SIDE_W  sideband tag captured with i_din_en
- i_quotient_en  in  1  divider quotient_en
- i_quotient  in  WIDTH_N  divider quotient
- i_clr_err  in  1  clears sticky error flags
- o_dout_en  out  1  result valid, one-cycle pulse
- o_dout  out  OUT_W  clamped result
- o_side  out  SIDE_W  tag matched to o_dout
- o_dz  out  1  result came from a zero denominator
- o_sat  out  1  result was clamped
- o_full  out  1  FIFO holds DEPTH entries
- o_cnt  out  log2(DEPTH)+1  in-flight entry count
- o_ovf  out  1  sticky: push while full
- o_udf  out  1  sticky: pop while empty

Behaviour:
- Reset: async on i_Rst high. All outputs 0, wr/rd pointers 0, count 0. Reset mid-operation discards all in-flight tags; quotients arriving after release with the FIFO empty count as underflow.
- Push: on i_din_en, write {i_side, (i_denom==0)} at wr_ptr and increment wr_ptr (wraps modulo DEPTH).
- Pop: on i_quotient_en, read at rd_ptr and increment rd_ptr (wraps).
- count: +1 on push only, -1 on pop only, unchanged when both occur in the same cycle. o_full = (count==DEPTH).
- Push while full and no pop: entry dropped, pointers unchanged, o_ovf set.
- Push while full with a simultaneous pop: legal, both performed, no error.
- Pop while empty: no output pulse, pointers unchanged, o_udf set.
- Push and pop in the same cycle with count==0: pop is underflow, push is performed. There is no bypass: the divider always has latency >= 1.
- Sticky flags: o_ovf and o_udf stay set until i_clr_err=1 for one cycle. If a new error and i_clr_err coincide, the flag remains set.
- Output latency: o_dout_en is exactly 1 cycle after an accepted i_quotient_en. o_dout, o_side, o_dz and o_sat are registered, and hold their value between pulses.
- Clamp, SIGNED=1: range [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Out-of-range quotients saturate to the nearest bound with o_sat=1.
- Clamp, SIGNED=0: values > 2^OUT_W-1 give all-ones with o_sat=1.
- Divide by zero (stored flag = 1): o_dout is the positive maximum (SIGNED=1: 2^(OUT_W-1)-1; SIGNED=0: all-ones), o_dz=1, o_sat=0, i_quotient ignored.
- The FIFO is register-based. Reads are combinational from rd_ptr; the output is registered.

Test Plan:
- Reset, then push tags 0x0001..0x0004 (denom 5), with quotients 3, 7, 9, 1 arriving 4 cycles later -> o_dout 3, 7, 9, 1 with o_side 0x0001..0x0004, each 1 cycle after its quotient_en; o_cnt returns to 0.
- SIGNED=1, OUT_W=8: quotients 0x0200, 0xFF00, 0xFFF6, 0x007F -> o_dout 0x7F (sat), 0x80 (sat), 0xF6 (no sat), 0x7F (no sat).
- Push with i_denom=0, tag 0xABCD, quotient 0x1234 -> o_dout 0x7F, o_dz=1, o_sat=0, o_side 0xABCD. Repeat with SIGNED=0 -> o_dout 0xFF.
- 16 pushes with no pops -> o_full=1, o_cnt=16. A 17th push -> o_ovf=1, o_cnt stays 16. Push plus pop in the same cycle while full -> o_cnt stays 16, no new error. i_clr_err -> o_ovf=0.
- quotient_en with the FIFO empty -> no o_dout_en pulse, o_udf=1. Simultaneous push/pop at empty -> o_udf=1, o_cnt=1.
- Assert i_Rst with 5 entries in flight -> o_cnt=0, all outputs 0. A quotient_en after release -> o_udf=1.
